// File: rtl/matmul_mac_sequencer.sv
// matmul_mac_sequencer
//   Sequences one shared MAC unit to compute C = A x B for N x N matrices of
//   unsigned 8-bit elements. Each output element takes 10 cycles:
//   FETCH0 -> ACCUM (N-1 cycles) -> DRAIN -> WRITE. Elements are visited
//   row-major (j fastest, then i). A DONE cycle follows the last write.
//
// Ports
//   i_clock       system clock, rising edge
//   i_resetn      synchronous active-low reset
//   i_start       one-cycle request to begin a multiply, honoured only in IDLE
//   o_busy        high from FETCH0 of element 0 through WRITE of the last element
//   o_done        one-cycle pulse after the last C write
//   o_a_addr      A memory read address, i*N+k
//   o_b_addr      B memory read address, k*N+j
//   o_mac_clear   MAC synchronous clear; MAC accumulates while low
//   i_mac_result  MAC accumulator output
//   o_c_we        C memory write enable
//   o_c_addr      C write address, i*N+j
//   o_c_data      C write data, pass-through of i_mac_result during WRITE

module matmul_mac_sequencer #(
    parameter int N     = 8,
    parameter int AW    = 6,
    parameter int ACC_W = 19
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW-1:0]    o_a_addr,
    output logic [AW-1:0]    o_b_addr,
    output logic             o_mac_clear,
    input  logic [ACC_W-1:0] i_mac_result,
    output logic             o_c_we,
    output logic [AW-1:0]    o_c_addr,
    output logic [ACC_W-1:0] o_c_data
);

    // Width of one matrix index; N is a power of two so AW = 2*CW.
    localparam int CW = AW / 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_i;
    logic [CW-1:0]   r_j;
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   w_i_nxt;
    logic [CW-1:0]   w_j_nxt;
    logic [CW-1:0]   w_k_nxt;

    // Last issued operand addresses, held outside FETCH0/ACCUM.
    logic [AW-1:0]   r_a_hold;
    logic [AW-1:0]   r_b_hold;

    logic            w_issue;
    logic            w_busy;
    logic            w_done;
    logic            w_clear;
    logic            w_we;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_a_hold <= '0;
            r_b_hold <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_a_hold <= o_a_addr;
            r_b_hold <= o_b_addr;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_issue     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_clear     = 1'b1;
        w_we        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH0;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                end
            end

            S_FETCH0: begin
                // k is 0 here; the MAC is cleared while the first
                // operands are still in flight from the memories.
                w_busy      = 1'b1;
                w_issue     = 1'b1;
                w_k_nxt     = CW'(1);
                w_state_nxt = S_ACCUM;
            end

            S_ACCUM: begin
                w_busy  = 1'b1;
                w_issue = 1'b1;
                w_clear = 1'b0;
                w_k_nxt = r_k + CW'(1);
                if (r_k == LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                w_busy      = 1'b1;
                w_clear     = 1'b0;
                w_state_nxt = S_WRITE;
            end

            S_WRITE: begin
                w_busy  = 1'b1;
                w_we    = 1'b1;
                w_k_nxt = '0;
                if ((r_i == LAST) && (r_j == LAST)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    // Row-major advance: {i,j} as one counter carries j into i.
                    {w_i_nxt, w_j_nxt} = {r_i, r_j} + AW'(1);
                    w_state_nxt        = S_FETCH0;
                end
            end

            S_DONE: begin
                w_done      = 1'b1;
                w_i_nxt     = '0;
                w_j_nxt     = '0;
                w_k_nxt     = '0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_mac_clear = w_clear;
    assign o_c_we      = w_we;
    assign o_a_addr    = w_issue ? {r_i, r_k} : r_a_hold;
    assign o_b_addr    = w_issue ? {r_k, r_j} : r_b_hold;
    assign o_c_addr    = {r_i, r_j};
    assign o_c_data    = w_we ? i_mac_result : '0;

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// tb_matmul_mac_sequencer
//   Directed bench: models the two synchronous-read operand memories and the
//   MAC around the sequencer, logs every C write, done pulse and busy cycle,
//   and compares against hand-derived matrix products and cycle timing.

module tb_matmul_mac_sequencer;

    localparam int N     = 8;
    localparam int AW    = 6;
    localparam int ACC_W = 19;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic             busy;
    logic             done;
    logic [AW-1:0]    a_addr;
    logic [AW-1:0]    b_addr;
    logic             mac_clear;
    logic [ACC_W-1:0] mac_result;
    logic             c_we;
    logic [AW-1:0]    c_addr;
    logic [ACC_W-1:0] c_data;

    always #5 clk = ~clk;

    matmul_mac_sequencer #(.N(N), .AW(AW), .ACC_W(ACC_W)) dut (
        .i_clock      (clk),
        .i_resetn     (resetn),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_a_addr     (a_addr),
        .o_b_addr     (b_addr),
        .o_mac_clear  (mac_clear),
        .i_mac_result (mac_result),
        .o_c_we       (c_we),
        .o_c_addr     (c_addr),
        .o_c_data     (c_data)
    );

    // Environment: operand memories (1-cycle read) and the MAC.
    logic [7:0]       mem_a [0:63];
    logic [7:0]       mem_b [0:63];
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [ACC_W-1:0] acc;

    always @(posedge clk) begin
        a_q <= mem_a[a_addr];
        b_q <= mem_b[b_addr];
        if (mac_clear) acc <= '0;
        else           acc <= acc + ACC_W'(a_q) * ACC_W'(b_q);
    end
    assign mac_result = acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity log
    bit log_en = 1'b0;
    int wr_n, done_n, done_cyc, busy_n, busy_first, busy_last;
    int wr_addr [0:255];
    int wr_data [0:255];
    int wr_cyc  [0:255];

    always @(negedge clk) begin
        if (log_en) begin
            if (c_we) begin
                if (wr_n < 256) begin
                    wr_addr[wr_n] = int'(c_addr);
                    wr_data[wr_n] = int'(c_data);
                    wr_cyc[wr_n]  = cyc;
                end
                wr_n++;
            end
            if (done) begin
                if (done_n == 0) done_cyc = cyc;
                done_n++;
            end
            if (busy) begin
                if (busy_n == 0) busy_first = cyc;
                busy_last = cyc;
                busy_n++;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_n       = 0;
        done_n     = 0;
        done_cyc   = -1;
        busy_n     = 0;
        busy_first = -1;
        busy_last  = -1;
        log_en     = 1'b1;
    endtask

    // mode 0: A = I, B[r][c] = 8r+c
    // mode 1: A = B = all 255
    // mode 2: A[r][c] = r+1, B[r][c] = c+1
    task automatic load(input int mode);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0: begin
                        mem_a[r*N+c] = (r == c) ? 8'd1 : 8'd0;
                        mem_b[r*N+c] = 8'(r*N + c);
                    end
                    1: begin
                        mem_a[r*N+c] = 8'd255;
                        mem_b[r*N+c] = 8'd255;
                    end
                    default: begin
                        mem_a[r*N+c] = 8'(r + 1);
                        mem_b[r*N+c] = 8'(c + 1);
                    end
                endcase
            end
        end
    endtask

    function automatic int exp_c(input int mode, input int q);
        case (mode)
            0:       return q;
            1:       return 520200;
            default: return 8 * (q / 8 + 1) * (q % 8 + 1);
        endcase
    endfunction

    task automatic start_run(output int s);
        tick();
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
    endtask

    // Waits for the first done pulse, optionally re-pulsing start at
    // offsets p1/p2 (relative to s) to show it is ignored while busy.
    task automatic wait_done(input int s, input int p1, input int p2, input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            tick();
            start = (cyc == s + p1) || (cyc == s + p2);
            n++;
        end
        start = 1'b0;
        if (done_n == 0) check("done_timeout", 0, 1);
        repeat (5) tick();
    endtask

    task automatic verify_writes(input string t, input int mode, input int s, input int base);
        for (int q = 0; q < 64; q++) begin
            check($sformatf("%s_addr%0d", t, q), wr_addr[base+q], q);
            check($sformatf("%s_data%0d", t, q), wr_data[base+q], exp_c(mode, q));
            check($sformatf("%s_cyc%0d", t, q), wr_cyc[base+q] - s, 10 + 10*q);
        end
    endtask

    task automatic verify_run(input string t, input int mode, input int s);
        check({t, "_nwr"}, wr_n, 64);
        verify_writes(t, mode, s, 0);
        check({t, "_done_cyc"}, done_cyc - s, 641);
        check({t, "_done_n"}, done_n, 1);
        check({t, "_busy_first"}, busy_first - s, 1);
        check({t, "_busy_last"}, busy_last - s, 640);
        check({t, "_busy_n"}, busy_n, 640);
    endtask

    initial begin
        int s;
        int n;
        resetn = 1'b0;
        start  = 1'b0;
        load(0);

        // Reset state
        repeat (3) tick();
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_cwe",   int'(c_we), 0);
        check("rst_aaddr", int'(a_addr), 0);
        check("rst_baddr", int'(b_addr), 0);
        check("rst_caddr", int'(c_addr), 0);
        check("rst_cdata", int'(c_data), 0);
        check("rst_clear", int'(mac_clear), 1);
        resetn = 1'b1;
        tick();

        // Identity A: C equals B
        clear_log();
        load(0);
        start_run(s);
        wait_done(s, -100, -100, 800);
        verify_run("ident", 0, s);

        // All 255: maximum element value, no wrap
        clear_log();
        load(1);
        start_run(s);
        wait_done(s, -100, -100, 800);
        verify_run("max", 1, s);

        // Outer-product style operands
        clear_log();
        load(2);
        start_run(s);
        wait_done(s, -100, -100, 800);
        verify_run("outer", 2, s);
        check("outer_c77", wr_data[63], 512);
        check("outer_c03", wr_data[3], 32);

        // start re-pulsed mid-run is ignored
        clear_log();
        load(0);
        start_run(s);
        wait_done(s, 45, 295, 800);
        verify_run("repulse", 0, s);

        // Mid-run reset for one cycle
        clear_log();
        load(2);
        start_run(s);
        while (cyc < s + 295) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mrst_busy",  int'(busy), 0);
        check("mrst_cwe",   int'(c_we), 0);
        check("mrst_clear", int'(mac_clear), 1);
        check("mrst_done",  int'(done), 0);
        check("mrst_nwr",   wr_n, 29);
        repeat (20) tick();
        check("mrst_nwr_idle", wr_n, 29);
        check("mrst_done_idle", done_n, 0);
        clear_log();
        start_run(s);
        wait_done(s, -100, -100, 800);
        verify_run("postrst", 2, s);

        // start held high: back-to-back runs
        clear_log();
        load(2);
        tick();
        start = 1'b1;
        s     = cyc;
        n     = 0;
        while (wr_n < 128 && n < 1400) begin
            tick();
            n++;
        end
        start = 1'b0;
        repeat (5) tick();
        check("hold_nwr", wr_n, 128);
        verify_writes("hold1", 2, s, 0);
        verify_writes("hold2", 2, s + 642, 64);
        check("hold_done_cyc", done_cyc - s, 641);
        check("hold_done_n", done_n, 2);
        check("hold_busy_n", busy_n, 1280);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
